// File: rtl/write_buffer.sv
// In-order store buffer between the MEM stage and the AXI write adapter.
// Define WRITE_BUFFER_FWD_EN to compare loads word-wise against every queued entry.
module write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic [3:0]  mem_sel,
   output logic        stall_req,
   input  logic [31:0] ld_addr,
   output logic        ld_conflict,
   output logic        we,
   output logic [31:0] address,
   output logic [31:0] data,
   output logic [3:0]  select,
   input  logic        write_done,
   output logic        empty,
   output logic        full
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic [31:0]   r_addr [DEPTH];
   logic [31:0]   r_data [DEPTH];
   logic [3:0]    r_sel  [DEPTH];
   logic          w_push;
   logic          w_pop;
   logic          w_unused_ld;

   assign full      = (r_count == FULL_CNT);
   assign empty     = (r_count == '0);
   assign stall_req = mem_we && full;
   // A store arriving while full waits even if a pop lands on the same edge.
   assign w_push    = mem_we && !full;

   assign address = r_addr[r_rd_ptr];
   assign data    = r_data[r_rd_ptr];
   assign select  = r_sel[r_rd_ptr];

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      we          = 1'b0;
      case (r_state)
         S_IDLE:  if (r_count != '0) w_state_nxt = S_ISSUE;
         S_ISSUE: begin
            we          = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT:  if (write_done) begin
            w_pop       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= mem_addr;
         r_data[r_wr_ptr] <= mem_data;
         r_sel[r_wr_ptr]  <= mem_sel;
      end
   end

`ifdef WRITE_BUFFER_FWD_EN
   logic          w_hit;
   logic [PW-1:0] w_off;

   // An entry is live when its distance from the head is below the count.
   always_comb begin
      w_hit = 1'b0;
      w_off = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_off = PW'(i) - r_rd_ptr;
         if (({1'b0, w_off} < r_count) && (r_addr[i][31:2] == ld_addr[31:2]))
            w_hit = 1'b1;
      end
   end

   assign ld_conflict = w_hit;
   assign w_unused_ld = ^ld_addr[1:0];
`else
   assign ld_conflict = !empty;
   assign w_unused_ld = ^ld_addr;
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_write_buffer;

   localparam int DEPTH = 4;
`ifdef WRITE_BUFFER_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic [3:0]  mem_sel;
   logic        stall_req;
   logic [31:0] ld_addr;
   logic        ld_conflict;
   logic        we;
   logic [31:0] address;
   logic [31:0] data;
   logic [3:0]  select;
   logic        write_done;
   logic        empty;
   logic        full;

   always #5 clk = ~clk;

   write_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_sel(mem_sel),
      .stall_req(stall_req), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
      .we(we), .address(address), .data(data), .select(select),
      .write_done(write_done), .empty(empty), .full(full)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } st_t;

   st_t mq[$];
   bit  m_wait;
   int  issued;

   typedef struct {
      logic        we_in;
      logic [31:0] a;
      logic        wd;
      logic        e_stall;
      logic        e_full;
      logic        e_empty;
      logic        e_we;
      logic [31:0] e_addr;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_data   = '0;
      mem_sel    = '0;
      write_done = 1'b0;
      ld_addr    = '0;
      tick();
      tick();
      reset = 1'b0;
      mq.delete();
      m_wait = 1'b0;
      issued = 0;
   endtask

   function automatic bit model_conflict();
      if (FWD) begin
         foreach (mq[i])
            if (mq[i].a[31:2] == ld_addr[31:2]) return 1'b1;
         return 1'b0;
      end
      return mq.size() != 0;
   endfunction

   // One cycle: compare outputs against the model, clock, then advance the model.
   task automatic mstep();
      bit  push, pop, saw_we;
      st_t ent;
      #1;
      check("stall_req", stall_req, (mem_we && mq.size() == DEPTH));
      check("full", full, (mq.size() == DEPTH));
      check("empty", empty, (mq.size() == 0));
      check("ld_conflict", ld_conflict, model_conflict());
      if (m_wait) check("we_while_waiting", we, 0);
      if (we) begin
         check("issue_pending", (mq.size() != 0), 1);
         if (mq.size() != 0) begin
            check("head_addr", address, mq[0].a);
            check("head_data", data, mq[0].d);
            check("head_sel", select, mq[0].s);
         end
         issued++;
      end
      saw_we = we;
      push   = mem_we && (mq.size() < DEPTH);
      pop    = m_wait && write_done;
      ent    = '{a: mem_addr, d: mem_data, s: mem_sel};
      tick();
      if (pop) begin
         void'(mq.pop_front());
         m_wait = 1'b0;
      end
      if (push) mq.push_back(ent);
      if (saw_we) m_wait = 1'b1;
   endtask

   // Streams n stores at one per cycle; write_done answers each we two cycles later.
   task automatic mrun(input int n, input logic [31:0] base, input string nm);
      int idx = 0;
      int timer = 0;
      int cyc = 0;
      bit acc, wsaw;
      while (!(idx == n && mq.size() == 0) && cyc < 300) begin
         mem_we     = (idx < n);
         mem_addr   = base + 32'(idx * 4);
         mem_data   = 32'hA5A5_0000 + 32'(idx);
         mem_sel    = 4'(idx + 1);
         write_done = (timer == 2);
         acc  = mem_we && (mq.size() < DEPTH);
         #1;
         wsaw = we;
         mstep();
         if (acc) idx++;
         if (write_done) timer = 0;
         else if (timer > 0) timer++;
         if (wsaw) timer = 1;
         cyc++;
      end
      mem_we = 1'b0;
      write_done = 1'b0;
      check({nm, "_accepted"}, idx, n);
      check({nm, "_issued"}, issued, n);
      check({nm, "_finished_in_budget"}, (cyc < 300), 1);
   endtask

   task automatic serve(input logic [31:0] ea, input string nm);
      int n = 0;
      #1;
      while (we !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({nm, "_issue_in_time"}, (n < 20), 1);
      check({nm, "_addr"}, address, ea);
      check({nm, "_data"}, data, ~ea);
      tick();
      check({nm, "_we_one_cycle"}, we, 0);
      tick();
      write_done = 1'b1;
      tick();
      write_done = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // ---- reset values and single store ----
      do_reset();
      #1;
      check("rst_we", we, 0);
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_stall", stall_req, 0);
      check("rst_ld_conflict", ld_conflict, 0);
      mem_we = 1'b1; mem_addr = 32'h1000_0010; mem_data = 32'hDEAD_BEEF; mem_sel = 4'hF;
      #1;
      check("t1_stall", stall_req, 0);
      tick();
      mem_we = 1'b0;
      #1;
      check("t1_we_early", we, 0);
      check("t1_not_empty", empty, 0);
      tick();
      check("t1_we", we, 1);
      check("t1_addr", address, 32'h1000_0010);
      check("t1_data", data, 32'hDEAD_BEEF);
      check("t1_sel", select, 4'hF);
      tick();
      check("t1_we_drop", we, 0);
      tick();
      tick();
      write_done = 1'b1;
      #1;
      check("t1_empty_before_pop", empty, 0);
      tick();
      write_done = 1'b0;
      #1;
      check("t1_empty_after_pop", empty, 1);

      // ---- fill to DEPTH with write_done withheld (vector table) ----
      tbl[0] = '{1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 32'h4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 32'h8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[3] = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[4] = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      tbl[5] = '{1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
      tbl[6] = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         mem_we = tbl[i].we_in; mem_addr = tbl[i].a; mem_data = ~tbl[i].a; mem_sel = 4'hF;
         write_done = tbl[i].wd;
         #1;
         check($sformatf("vec%0d_stall", i), stall_req, tbl[i].e_stall);
         check($sformatf("vec%0d_full", i), full, tbl[i].e_full);
         check($sformatf("vec%0d_empty", i), empty, tbl[i].e_empty);
         check($sformatf("vec%0d_we", i), we, tbl[i].e_we);
         if (tbl[i].e_we) check($sformatf("vec%0d_addr", i), address, tbl[i].e_addr);
         tick();
      end
      mem_we = 1'b0;
      write_done = 1'b1;
      tick();
      write_done = 1'b0;
      serve(32'h8, "fill_e2");
      serve(32'hC, "fill_e3");
      serve(32'h10, "fill_e4");
      #1;
      check("fill_empty_end", empty, 1);

      // ---- spurious write_done in IDLE and ISSUE ----
      do_reset();
      write_done = 1'b1;
      mstep();
      mem_we = 1'b1; mem_addr = 32'h4000_0000; mem_data = 32'h1234_5678; mem_sel = 4'h3;
      write_done = 1'b0;
      mstep();
      mem_we = 1'b0; write_done = 1'b1;
      mstep();
      check("spur_issue_we", we, 1);
      mstep();
      write_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("spur_wait_not_empty", empty, 0);
         mstep();
      end
      write_done = 1'b1;
      mstep();
      write_done = 1'b0;
      check("spur_done_empty", empty, 1);

      // ---- pointer wrap: 10 stores streamed ----
      do_reset();
      mrun(10, 32'h3000_0000, "wrap");

      // ---- load conflict ----
      do_reset();
      mem_we = 1'b1; mem_addr = 32'h2000_0008; mem_data = 32'h55AA_55AA; mem_sel = 4'hF;
      tick();
      mem_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ld_addr = 32'h2000_000B;
         #1;
         check("ldc_same_word", ld_conflict, 1);
         ld_addr = 32'h2000_000C;
         #1;
         check("ldc_next_word", ld_conflict, FWD ? 0 : 1);
         tick();
      end

      // ---- reset while WAIT with 3 entries ----
      do_reset();
      for (int i = 0; i < 3; i++) begin
         mem_we = 1'b1; mem_addr = 32'h6000_0000 + 32'(i * 4); mem_data = 32'(i); mem_sel = 4'hF;
         tick();
      end
      mem_we = 1'b0;
      #1;
      check("rw_wait_we", we, 0);
      check("rw_pre_empty", empty, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rw_empty", empty, 1);
      check("rw_we", we, 0);
      check("rw_full", full, 0);
      write_done = 1'b1;
      tick();
      write_done = 1'b0;
      check("rw_late_done_empty", empty, 1);
      for (int i = 0; i < 3; i++) begin
         check("rw_no_issue", we, 0);
         tick();
      end
      mq.delete(); m_wait = 1'b0; issued = 0;
      mrun(1, 32'h7000_0000, "rw_after");

      // ---- randomized traffic ----
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if (!(mem_we && mq.size() == DEPTH)) begin
            mem_we   = 1'($urandom_range(0, 1));
            mem_addr = 32'h5000_0000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            mem_data = $urandom;
            mem_sel  = 4'($urandom_range(0, 15));
         end
         ld_addr    = 32'h5000_0000 + 32'($urandom_range(0, 35));
         write_done = ($urandom_range(0, 3) == 0);
         mstep();
      end
      mem_we = 1'b0;
      for (int c = 0; c < 200 && mq.size() != 0; c++) begin
         write_done = 1'b1;
         mstep();
      end
      write_done = 1'b0;
      #1;
      check("rand_model_drained", mq.size(), 0);
      check("rand_empty", empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
